// File: rtl/uart_array_receiver.sv
// Receives eight consecutive 8N1 UART frames into a 64-bit array; byte k lands at [8k+7:8k].
// Define UART_RX_TIMEOUT_EN to discard a partial array after timeout_bits idle bit periods.
`timescale 1ns/1ps
module uart_array_receiver #(
  parameter int unsigned clks_per_bit = 868,
  parameter int unsigned timeout_bits = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [63:0] input_array,
  output logic        bytes_are_received,
  output logic        receive_active,
  output logic        framing_error
);

`ifdef UART_RX_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [24:0] HALF_LAST    = 25'((clks_per_bit - 1) / 2);
  localparam logic [24:0] BIT_LAST     = 25'(clks_per_bit - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(timeout_bits * clks_per_bit - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_e;

  state_e      state_q;
  logic        rx_meta_q;
  logic        rx_s_q;
  logic [24:0] cnt_q;
  logic [2:0]  byte_idx_q;
  logic [2:0]  bit_idx_q;
  logic [31:0] idle_cnt_q;
  logic [63:0] shadow_q;
  logic [63:0] array_q;
  logic        done_q;
  logic        active_q;
  logic        ferr_q;

  assign input_array        = array_q;
  assign bytes_are_received = done_q;
  assign receive_active     = active_q;
  assign framing_error      = ferr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      idle_cnt_q <= '0;
      shadow_q   <= '0;
      array_q    <= '0;
      done_q     <= 1'b0;
      active_q   <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          if (!rx_s_q) begin
            state_q    <= S_START;
            idle_cnt_q <= '0;
          end else if (TIMEOUT_EN && (byte_idx_q != '0)) begin
            // A line left idle mid-array abandons the partial array silently.
            if (idle_cnt_q == TIMEOUT_LAST) begin
              byte_idx_q <= '0;
              shadow_q   <= '0;
              active_q   <= 1'b0;
              idle_cnt_q <= '0;
            end else begin
              idle_cnt_q <= idle_cnt_q + 32'd1;
            end
          end else begin
            idle_cnt_q <= '0;
          end
        end

        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q <= S_DATA;
              if (byte_idx_q == '0) begin
                active_q <= 1'b1;
              end
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 25'd1;
          end
        end

        S_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q                            <= '0;
            shadow_q[{byte_idx_q, bit_idx_q}] <= rx_s_q;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
              state_q   <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 25'd1;
          end
        end

        S_STOP: begin
          // Sampling mid-stop and returning to IDLE leaves half a bit to catch the next start edge.
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              if (byte_idx_q == 3'd7) begin
                state_q <= S_DONE;
              end else begin
                byte_idx_q <= byte_idx_q + 3'd1;
                state_q    <= S_IDLE;
              end
            end else begin
              ferr_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 25'd1;
          end
        end

        S_DONE: begin
          array_q    <= shadow_q;
          done_q     <= 1'b1;
          active_q   <= 1'b0;
          byte_idx_q <= '0;
          state_q    <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_array_receiver.sv
// Scoreboard bench for uart_array_receiver: directed frames, queued expected arrays, decoupled monitor.
`timescale 1ns/1ps
module tb_uart_array_receiver;
  localparam int unsigned CPB = 16;
  localparam int unsigned TOB = 4;
  localparam longint unsigned LATENCY = 10 * CPB - 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic [63:0] input_array;
  logic        bytes_are_received;
  logic        receive_active;
  logic        framing_error;

  uart_array_receiver #(.clks_per_bit(CPB), .timeout_bits(TOB)) dut (
    .clk               (clk),
    .rst               (rst),
    .uart_rx           (uart_rx),
    .input_array       (input_array),
    .bytes_are_received(bytes_are_received),
    .receive_active    (receive_active),
    .framing_error     (framing_error)
  );

  always #5 clk = ~clk;

  int unsigned     n_checks = 0;
  int unsigned     n_fail = 0;
  longint unsigned cyc = 0;
  longint unsigned last_start = 0;
  logic [63:0]     exp_q[$];
  int              fe_pending = 0;
  logic            rst_edge = 1'b1;
  logic            prev_brx = 1'b0;
  logic [63:0]     prev_arr = '0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output event is matched against the scoreboard.
  always @(negedge clk) begin
    if (bytes_are_received) begin
      check64("pulse_overlap", {63'd0, framing_error}, 64'd0);
      check64("pulse_width", {63'd0, prev_brx}, 64'd0);
      if (exp_q.size() == 0) begin
        check64("unexpected_pulse", 64'd1, 64'd0);
      end else begin
        check64("array", input_array, exp_q.pop_front());
        check64("latency", cyc - last_start, LATENCY);
      end
    end
    if (framing_error) begin
      if (fe_pending > 0) begin
        fe_pending--;
        n_checks++;
      end else begin
        check64("unexpected_framing_error", 64'd1, 64'd0);
      end
    end
    if ((input_array !== prev_arr) && !bytes_are_received && !rst_edge)
      check64("array_stability", input_array, prev_arr);
    prev_brx = bytes_are_received;
    prev_arr = input_array;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    last_start = cyc;
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_run(input logic [7:0] first, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) send_byte(first + 8'(k), 1'b1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000 && (exp_q.size() != 0 || fe_pending != 0); i++) @(negedge clk);
    check64(name, 64'(exp_q.size()) + 64'(fe_pending), 64'd0);
  endtask

  initial begin
    #201000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check64("reset_array", input_array, 64'd0);
    check64("reset_pulse", {63'd0, bytes_are_received}, 64'd0);
    check64("reset_active", {63'd0, receive_active}, 64'd0);
    check64("reset_ferr", {63'd0, framing_error}, 64'd0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    // Full array, back-to-back frames.
    exp_q.push_back(64'h0807060504030201);
    send_run(8'h01, 3);
    check64("active_mid_array", {63'd0, receive_active}, 64'd1);
    send_run(8'h04, 5);
    drain("full_drain");
    check64("active_after_done", {63'd0, receive_active}, 64'd0);

    // Short low glitch must be rejected as a false start.
    repeat (2 * CPB) @(negedge clk);
    uart_rx = 1'b0;
    repeat (5) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check64("glitch_active", {63'd0, receive_active}, 64'd0);
    exp_q.push_back(64'hF8F9FAFBFCFDFEFF);
    for (int k = 0; k < 8; k++) send_byte(8'hFF - 8'(k), 1'b1);
    drain("glitch_drain");

    // Framing error on byte 3, then byte 3 resent.
    repeat (2 * CPB) @(negedge clk);
    exp_q.push_back(64'h3736353433323130);
    send_run(8'h30, 3);
    fe_pending++;
    send_byte(8'hEE, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check64("ferr_seen", 64'(fe_pending), 64'd0);
    send_run(8'h33, 5);
    drain("ferr_drain");

    // Reset during byte 5 data bits discards everything.
    repeat (2 * CPB) @(negedge clk);
    send_run(8'hC0, 5);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check64("midreset_array", input_array, 64'd0);
    check64("midreset_pulse", {63'd0, bytes_are_received}, 64'd0);
    check64("midreset_active", {63'd0, receive_active}, 64'd0);
    check64("midreset_ferr", {63'd0, framing_error}, 64'd0);
    repeat (3 * CPB) @(negedge clk);
    exp_q.push_back(64'hA7A6A5A4A3A2A1A0);
    send_run(8'hA0, 8);
    drain("midreset_drain");

    // Inter-byte idle gap longer than the timeout.
    repeat (2 * CPB) @(negedge clk);
    send_run(8'hE0, 3);
    repeat (5 * CPB) @(negedge clk);
`ifdef UART_RX_TIMEOUT_EN
    check64("timeout_active", {63'd0, receive_active}, 64'd0);
    exp_q.push_back(64'h1716151413121110);
`else
    check64("timeout_active", {63'd0, receive_active}, 64'd1);
    exp_q.push_back(64'h1413121110E2E1E0);
`endif
    send_run(8'h10, 8);
    drain("timeout_drain");

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
